// File: rtl/booth_result_uart_tx.sv
// Booth result UART transmitter: sends the signed product as ASCII '0'/'1'
// digits, MSB first, 8N1 framing, optionally terminated by CR LF.
module booth_result_uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int RESULT_W     = 8,
    parameter int SEND_CRLF    = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [RESULT_W-1:0] result,
    output logic                busy,
    output logic                done,
    output logic                TX_OUT
);

    localparam int NCHAR = RESULT_W + 2 * SEND_CRLF;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CIW   = $clog2(NCHAR + 1);

    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CIW-1:0] DIGITS    = CIW'(RESULT_W);
    localparam logic [CIW-1:0] CHAR_LAST = CIW'(NCHAR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state, w_state_n;
    logic [CW-1:0]       r_cnt, w_cnt_n;
    logic [2:0]          r_bit, w_bit_n;
    logic [CIW-1:0]      r_char_idx, w_char_idx_n;
    logic [RESULT_W-1:0] r_res, w_res_n;
    logic [RESULT_W-1:0] w_shift;
    logic [7:0]          w_char;
    logic                r_tx, w_tx_n;
    logic                r_busy, w_busy_n;
    logic                r_done, w_done_n;
    logic                w_bit_end;

    assign TX_OUT    = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign w_bit_end = (r_cnt == CNT_LAST);

    // Shifting left by char_idx brings digit RESULT_W-1-char_idx to the MSB.
    assign w_shift = r_res << r_char_idx;

    always_comb begin
        if (r_char_idx < DIGITS) begin
            w_char = {7'h18, w_shift[RESULT_W-1]};
        end else if (r_char_idx == DIGITS) begin
            w_char = 8'h0D;
        end else begin
            w_char = 8'h0A;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_bit_n      = r_bit;
        w_char_idx_n = r_char_idx;
        w_res_n      = r_res;
        w_done_n     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_res_n      = result;
                    w_char_idx_n = '0;
                    w_cnt_n      = '0;
                    w_state_n    = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = S_DATA;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_n = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    if (r_char_idx == CHAR_LAST) begin
                        w_state_n = S_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_char_idx_n = r_char_idx + 1'b1;
                        w_state_n    = S_START;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Outputs are registered from the next state so the line changes
        // in the same cycle the FSM enters a new bit.
        w_busy_n = (w_state_n != S_IDLE);
        unique case (w_state_n)
            S_START: w_tx_n = 1'b0;
            S_DATA:  w_tx_n = w_char[w_bit_n];
            default: w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_char_idx <= '0;
            r_res      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_char_idx <= w_char_idx_n;
            r_res      <= w_res_n;
            r_tx       <= w_tx_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
        end
    end

endmodule
